// File: rtl/bsg_cgol_pkg.sv
// rtl/bsg_cgol_pkg.sv - shared types and helpers for the Game-of-Life controller
package bsg_cgol_pkg;

    typedef enum logic [1:0] {eIdle, eLoad, eSim, eDone} cgol_state_e;

    function automatic int cell_idx(input int r, input int c, input int width = 8);
        return r * width + c;
    endfunction

endpackage

// File: rtl/bsg_cgol_ctrl_if.sv
// rtl/bsg_cgol_ctrl_if.sv - host-side board request/result channel of bsg_cgol_ctrl
interface bsg_cgol_ctrl_if #(
    parameter int num_cells_p   = 64,
    parameter int frame_width_p = 10
);
    logic                     v_i;
    logic                     ready_o;
    logic [num_cells_p-1:0]   data_i;
    logic [frame_width_p-1:0] frames_i;
    logic                     v_o;
    logic [num_cells_p-1:0]   data_o;
    logic                     yumi_i;

    modport master (output v_i, data_i, frames_i, yumi_i, input ready_o, v_o, data_o);
    modport slave  (input v_i, data_i, frames_i, yumi_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_cgol_frame_counter.sv
// rtl/bsg_cgol_frame_counter.sv - loadable generation down-counter with one/zero flags
module bsg_cgol_frame_counter #(
    parameter int width_p = 10
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [width_p-1:0] val_i,
    output logic               one_o,
    output logic               zero_o
);
    logic [width_p-1:0] cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_r <= '0;
        end else if (load_i) begin
            cnt_r <= val_i;
        end else if (dec_i) begin
            cnt_r <= cnt_r - width_p'(1);
        end
    end

    assign one_o  = (cnt_r == width_p'(1));
    assign zero_o = (cnt_r == '0);
endmodule

// File: rtl/bsg_cgol_ctrl.sv
// rtl/bsg_cgol_ctrl.sv - loads a board into the cell array, runs N generations, returns the result
// Optional BSG_CGOL_CTRL_PAUSE_EN adds pause_i, which stalls the simulation phase.
module bsg_cgol_ctrl
    import bsg_cgol_pkg::*;
#(
    parameter  int board_width_p  = 8,
    parameter  int board_height_p = 8,
    parameter  int max_frames_p   = 1023,
    localparam int num_cells_lp   = board_width_p * board_height_p,
    localparam int frame_width_lp = $clog2(max_frames_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bsg_cgol_ctrl_if.slave          host,
`ifdef BSG_CGOL_CTRL_PAUSE_EN
    input  logic                    pause_i,
`endif
    output logic                    update_o,
    output logic [num_cells_lp-1:0] update_val_o,
    output logic                    en_o,
    input  logic [num_cells_lp-1:0] cells_i
);
    cgol_state_e             state_r, state_n;
    logic [num_cells_lp-1:0] board_r;
    logic                    cnt_load, cnt_dec, cnt_one, cnt_zero;
    logic                    pause;

`ifdef BSG_CGOL_CTRL_PAUSE_EN
    assign pause = pause_i;
`else
    assign pause = 1'b0;
`endif

    bsg_cgol_frame_counter #(.width_p(frame_width_lp)) frame_cnt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .load_i    (cnt_load),
        .dec_i     (cnt_dec),
        .val_i     (host.frames_i),
        .one_o     (cnt_one),
        .zero_o    (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= eIdle;
            board_r <= '0;
        end else begin
            state_r <= state_n;
            if (cnt_load) begin
                board_r <= host.data_i;
            end
        end
    end

    // Outputs decode from the state register only, so an async reset drops en_o/update_o at once.
    always_comb begin
        state_n      = state_r;
        host.ready_o = 1'b0;
        host.v_o     = 1'b0;
        update_o     = 1'b0;
        en_o         = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state_r)
            eIdle: begin
                host.ready_o = 1'b1;
                if (host.v_i) begin
                    cnt_load = 1'b1;
                    state_n  = eLoad;
                end
            end
            eLoad: begin
                update_o = 1'b1;
                state_n  = cnt_zero ? eDone : eSim;
            end
            eSim: begin
                if (!pause) begin
                    en_o = 1'b1;
                    if (cnt_one) begin
                        state_n = eDone;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            eDone: begin
                host.v_o = 1'b1;
                if (host.yumi_i) begin
                    state_n = eIdle;
                end
            end
            default: state_n = eIdle;
        endcase
    end

    assign update_val_o = board_r;
    assign host.data_o  = cells_i;

    yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        host.yumi_i |-> host.v_o);
endmodule

// File: doc/bsg_cgol_ctrl.md
Name: bsg_cgol_ctrl

Overview:
- Controller that drives the board of Game-of-Life cells.
- Accepts a packed initial board and a generation count over a valid/ready input.
- Loads the board into every cell through the cells' update interface, then asserts the cell enable for the requested number of generations.
- Captures the cells' outputs and returns the final board over a valid/yumi output. It sits between the host/testbench-side interface and the cell array.

Parameters:
- board_width_p, 8, cells per row
- board_height_p, 8, rows
- max_frames_p, 1023, largest accepted generation count
- (derived, localparam) num_cells_lp = board_width_p*board_height_p; frame_width_lp = $clog2(max_frames_p+1)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  input board valid
- ready_o  out  1  controller can accept a board
- data_i  in  num_cells_lp  initial board; cell (r,c) at bit r*board_width_p+c
- frames_i  in  frame_width_lp  generations to simulate
- update_o  out  1  broadcast to all cells' update input
- update_val_o  out  num_cells_lp  per-cell update value, same bit order as data_i
- en_o  out  1  broadcast to all cells' enable
- cells_i  in  num_cells_lp  cell array data outputs, same bit order
- v_o  out  1  result valid
- data_o  out  num_cells_lp  final board
- yumi_i  in  1  consumer takes result; legal only while v_o=1

Behaviour:
- Reset is asynchronous and active-low. While reset_n_i=0, or on leaving reset:
  - state=IDLE
  - ready_o=1, v_o=0, update_o=0, en_o=0
  - board and frame registers cleared to 0
- A reset asserted mid-operation takes effect immediately. en_o and update_o drop without waiting for a clock edge, and the current job is discarded.
- The FSM has four states: IDLE, LOAD, SIM, DONE. Transitions:
  - IDLE: ready_o=1. On v_i&ready_o at an edge, register data_i into board_r and frames_i into cnt_r, then go to LOAD.
  - LOAD: exactly one cycle. update_o=1, en_o=0, update_val_o=board_r. Next state is DONE if cnt_r==0, else SIM.
  - SIM: en_o=1, update_o=0. cnt_r decrements each cycle. When cnt_r==1 at an edge, go to DONE. This gives exactly frames_i enable cycles.
  - DONE: v_o=1. data_o=cells_i, passed combinationally from the already-settled registered cell outputs. On yumi_i, go to IDLE.
- en_o and update_o are never asserted in the same cycle.
- update_val_o is held at board_r in all states; it is only meaningful while update_o=1.
- Latency: with acceptance at edge E0, v_o first rises after edge E0+frames_i+1.
  - frames_i=0 gives v_o one cycle after acceptance, with data_o equal to the loaded board.
- ready_o=0 outside IDLE. v_i in other states is ignored and no input is captured.
- frames_i > max_frames_p is truncated to frame_width_lp bits; no other checking is performed.
- yumi_i without v_o is illegal (assertion in simulation). A yumi_i in the same cycle as entry to DONE has no effect, because v_o is not yet high.
- No wrap-around: cnt_r never decrements below 1 in SIM.

Optional Feature:
- Macro: BSG_CGOL_CTRL_PAUSE_EN.
- With the macro defined:
  - An extra input port pause_i (1 bit) is present.
  - In SIM, pause_i=1 forces en_o=0 and freezes cnt_r and the state.
  - Generation count and result are unaffected; only latency extends by the number of paused cycles.
  - pause_i has no effect in other states.
- Without the macro: there is no pause_i port, and SIM runs uninterrupted.

Decomposition:
- Package bsg_cgol_pkg holds:
  - the state typedef (enum logic [1:0] {eIdle, eLoad, eSim, eDone})
  - a helper function cell_idx(r,c) returning r*width+c
- One natural sub-module: bsg_cgol_frame_counter.
  - Loadable down-counter with load_i, dec_i, val_i, and a one_o flag.
  - Reset asynchronous active-low.

Test Plan:
- Reset and frames=0: reset mid-SIM -> same cycle en_o=0, ready_o=1. Then submit data_i with bit 0 set, frames_i=0 -> one update_o pulse, no en_o, v_o=1 one cycle after acceptance, data_o bit 0 set.
- Blinker, 8x8 board: bits 17,18,19 set, frames_i=1 -> exactly one en_o cycle, data_o has bits 10,18,26. Repeat with frames_i=2 -> data_o has bits 17,18,19.
- Block still life: bits 9,10,17,18, frames_i=100 -> exactly 100 en_o cycles, v_o after edge E0+101, data_o unchanged.
- Handshake: hold yumi_i=0 for 5 cycles in DONE -> v_o and data_o stable, ready_o=0, v_i ignored. yumi_i=1 -> IDLE next cycle and back-to-back job accepted.
- Lone cell dies: single bit 27, frames_i=1 -> data_o=0. All-ones board, frames_i=1 -> only the 4 corner bits (0,7,56,63) survive.
- With BSG_CGOL_CTRL_PAUSE_EN: blinker, frames_i=3, pause_i high for 4 cycles mid-SIM -> en_o asserted for exactly 3 cycles, v_o delayed by 4 cycles, data_o has bits 10,18,26.
